// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// uart_pkg
// Purpose : Shared definitions for the UART receiver and transmitter:
//           FSM state encoding and oversampling / framing constants.
// Ports   : none (package)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

package uart_pkg;

    // Frame-level FSM states shared by the receive and transmit sides
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Baud ticks per bit period
    localparam int OVERSAMPLE  = 16;
    // Payload width of one frame
    localparam int DATA_BITS   = 8;
    // Tick index inside a bit at which data and stop bits are sampled
    localparam int STOP_SAMPLE = 15;
    // Tick index after start detection that lands in the middle of the start bit
    localparam int MID_START   = 7;

endpackage : uart_pkg

// File: rtl/uart_baud_gen.sv
//------------------------------------------------------------------------------
// uart_baud_gen
// Purpose : Free-running oversampling tick generator. Produces a one-clock
//           pulse every DIV clocks, DIV = UART_INPUT_CLK / (baud_rate * 16).
// Ports   : clk    - system clock
//           arst_n - asynchronous active-low reset
//           btick  - one-cycle pulse at 16x the baud rate
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int UART_INPUT_CLK = 100_000_000,
    parameter int baud_rate      = 9600
) (
    input  logic clk,
    input  logic arst_n,
    output logic btick
);

    localparam int DIV_RAW = UART_INPUT_CLK / (baud_rate * OVERSAMPLE);
    // A divisor below one would never tick; clamp so the counter stays legal
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == LAST);
    assign btick  = w_wrap;

    // Counter runs 0..DIV-1 and wraps on the same cycle that btick is high
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule : uart_baud_gen

// File: rtl/uart_rx.sv
//------------------------------------------------------------------------------
// uart_rx
// Purpose : 8N1 asynchronous serial receiver, LSB first, idle-high line,
//           16x oversampling. Each correctly framed byte is presented on
//           data_out with a one-cycle done strobe; a low stop bit gives a
//           one-cycle frame_err strobe instead and data_out is kept.
// Ports   : clk       - system clock
//           arst_n    - asynchronous active-low reset
//           rx_en     - new frames are accepted only while high
//           rx        - serial line, asynchronous to clk
//           data_out  - last correctly received byte
//           done      - one-cycle pulse when data_out updates
//           busy      - high from start-bit acceptance to end of frame
//           frame_err - one-cycle pulse when the stop bit samples low
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx
    import uart_pkg::*;
#(
    parameter int UART_INPUT_CLK = 100_000_000,
    parameter int baud_rate      = 9600
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       rx_en,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       done,
    output logic       busy,
    output logic       frame_err
);

    localparam logic [3:0] L_MID_START   = 4'(MID_START);
    localparam logic [3:0] L_STOP_SAMPLE = 4'(STOP_SAMPLE);
    localparam logic [2:0] L_LAST_BIT    = 3'(DATA_BITS - 1);

    logic        w_btick;
    logic        r_rxMeta;
    logic        r_rxSync;
    logic        w_rxS;

    uart_state_t r_state,    w_stateNext;
    logic [3:0]  r_sCnt,     w_sCntNext;
    logic [2:0]  r_bCnt,     w_bCntNext;
    logic [7:0]  r_shift,    w_shiftNext;
    logic [7:0]  r_dataOut,  w_dataOutNext;
    logic        r_done,     w_doneNext;
    logic        r_frameErr, w_frameErrNext;
    logic        r_busy,     w_busyNext;

    uart_baud_gen #(
        .UART_INPUT_CLK (UART_INPUT_CLK),
        .baud_rate      (baud_rate)
    ) u_baud_gen (
        .clk    (clk),
        .arst_n (arst_n),
        .btick  (w_btick)
    );

    // Two-flop synchroniser; resets to the idle (high) line level so that
    // reset release never looks like a falling edge by itself
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
        end else begin
            r_rxMeta <= rx;
            r_rxSync <= r_rxMeta;
        end
    end

    assign w_rxS = r_rxSync;

    // State and datapath registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state    <= IDLE;
            r_sCnt     <= '0;
            r_bCnt     <= '0;
            r_shift    <= '0;
            r_dataOut  <= '0;
            r_done     <= 1'b0;
            r_frameErr <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_sCnt     <= w_sCntNext;
            r_bCnt     <= w_bCntNext;
            r_shift    <= w_shiftNext;
            r_dataOut  <= w_dataOutNext;
            r_done     <= w_doneNext;
            r_frameErr <= w_frameErrNext;
            r_busy     <= w_busyNext;
        end
    end

    // Next-state logic. Everything advances only on baud ticks; the strobes
    // default low so they last exactly one clock.
    always_comb begin
        w_stateNext    = r_state;
        w_sCntNext     = r_sCnt;
        w_bCntNext     = r_bCnt;
        w_shiftNext    = r_shift;
        w_dataOutNext  = r_dataOut;
        w_doneNext     = 1'b0;
        w_frameErrNext = 1'b0;
        w_busyNext     = r_busy;

        case (r_state)
            IDLE: begin
                w_busyNext = 1'b0;
                if (w_btick && rx_en && !w_rxS) begin
                    w_stateNext = START;
                    w_sCntNext  = '0;
                    w_busyNext  = 1'b1;
                end
            end

            START: begin
                if (w_btick) begin
                    if (r_sCnt == L_MID_START) begin
                        // A line that is high again at mid start bit was a glitch
                        if (!w_rxS) begin
                            w_stateNext = DATA;
                            w_sCntNext  = '0;
                            w_bCntNext  = '0;
                        end else begin
                            w_stateNext = IDLE;
                            w_busyNext  = 1'b0;
                        end
                    end else begin
                        w_sCntNext = r_sCnt + 1'b1;
                    end
                end
            end

            DATA: begin
                if (w_btick) begin
                    if (r_sCnt == L_STOP_SAMPLE) begin
                        // LSB arrives first, so bits shift in from the top
                        w_shiftNext = {w_rxS, r_shift[7:1]};
                        w_sCntNext  = '0;
                        if (r_bCnt == L_LAST_BIT) begin
                            w_stateNext = STOP;
                        end else begin
                            w_bCntNext = r_bCnt + 1'b1;
                        end
                    end else begin
                        w_sCntNext = r_sCnt + 1'b1;
                    end
                end
            end

            STOP: begin
                if (w_btick) begin
                    if (r_sCnt == L_STOP_SAMPLE) begin
                        if (w_rxS) begin
                            w_dataOutNext = r_shift;
                            w_doneNext    = 1'b1;
                        end else begin
                            w_frameErrNext = 1'b1;
                        end
                        // Leaving at mid stop bit keeps a back-to-back start edge visible
                        w_stateNext = IDLE;
                        w_busyNext  = 1'b0;
                        w_sCntNext  = '0;
                    end else begin
                        w_sCntNext = r_sCnt + 1'b1;
                    end
                end
            end

            default: begin
                w_stateNext = IDLE;
                w_busyNext  = 1'b0;
            end
        endcase
    end

    assign data_out  = r_dataOut;
    assign done      = r_done;
    assign busy      = r_busy;
    assign frame_err = r_frameErr;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
//------------------------------------------------------------------------------
// tb_uart_rx
// Purpose : Directed self-checking bench for uart_rx. The receiver is built
//           with a small divisor (DIV = 10 clocks per tick, 160 clocks per
//           bit) so every frame stays short.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int CLK_NS = 10;
    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 10_000;
    // 1_600_000 / (10_000 * 16) = 10 clocks per tick, 16 ticks per bit
    localparam int BIT_NS = 16 * 10 * CLK_NS;
    // START 8 ticks + DATA 8*16 ticks + STOP 16 ticks, 10 clocks each
    localparam int BUSY_CLKS = (8 + 8 * 16 + 16) * 10;

    logic       clk    = 1'b0;
    logic       arst_n = 1'b0;
    logic       rx_en  = 1'b0;
    logic       rx     = 1'b1;
    logic [7:0] data_out;
    logic       done;
    logic       busy;
    logic       frame_err;

    int errors = 0;
    int checks = 0;

    int         doneCount   = 0;
    int         ferrCount   = 0;
    int         busyRise    = 0;
    int         bothHigh    = 0;
    int         busyRun     = 0;
    int         lastBusyLen = 0;
    logic       busyPrev    = 1'b0;
    logic [7:0] doneData[$];

    uart_rx #(
        .UART_INPUT_CLK (CLK_HZ),
        .baud_rate      (BAUD)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .rx_en     (rx_en),
        .rx        (rx),
        .data_out  (data_out),
        .done      (done),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #(CLK_NS / 2) clk = ~clk;

    // Event monitor sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (done) begin
            doneCount++;
            doneData.push_back(data_out);
        end
        if (frame_err) ferrCount++;
        if (done && frame_err) bothHigh++;
        if (busy && !busyPrev) busyRise++;
        if (busy) begin
            busyRun++;
        end else if (busyRun != 0) begin
            lastBusyLen = busyRun;
            busyRun     = 0;
        end
        busyPrev = busy;
    end

    // Hard time limit so the bench always terminates
    initial begin
        #(2_000_000);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
        end
    endtask

    // Drives one 8N1 frame LSB first. A low stop bit is held only past its
    // sampling point so the line is high again before any restart check.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            #(BIT_NS);
        end
        rx = stopBit;
        if (stopBit) begin
            #(BIT_NS);
        end else begin
            #(BIT_NS * 5 / 8);
            rx = 1'b1;
            #(BIT_NS * 3 / 8);
        end
    endtask

    initial begin
        int         d0, f0, b0, idx;
        logic [7:0] partial;

        $display("[TB] uart_rx bench start");

        // Reset state
        #25;
        checkOutput("rst_data_out",  32'(data_out),  32'h00);
        checkOutput("rst_done",      32'(done),      32'h0);
        checkOutput("rst_busy",      32'(busy),      32'h0);
        checkOutput("rst_frame_err", 32'(frame_err), 32'h0);
        @(negedge clk);
        arst_n = 1'b1;
        rx_en  = 1'b1;
        #(2 * BIT_NS);

        // Glitch: low for 3 tick periods, then high again
        d0 = doneCount; f0 = ferrCount; b0 = busyRise;
        rx = 1'b0;
        #(25 * CLK_NS);
        checkOutput("glitch_busy_up", 32'(busy), 32'h1);
        #(5 * CLK_NS);
        rx = 1'b1;
        #(90 * CLK_NS);
        checkOutput("glitch_busy_down", 32'(busy), 32'h0);
        #(BIT_NS);
        checkOutput("glitch_busy_rises", 32'(busyRise - b0), 32'd1);
        checkOutput("glitch_no_done",    32'(doneCount - d0), 32'd0);
        checkOutput("glitch_no_ferr",    32'(ferrCount - f0), 32'd0);
        checkOutput("glitch_data",       32'(data_out), 32'h00);

        // Single frame 8'hE6
        d0 = doneCount; f0 = ferrCount;
        applyStimulus(8'hE6, 1'b1);
        #(BIT_NS);
        checkOutput("e6_done_count", 32'(doneCount - d0), 32'd1);
        checkOutput("e6_data",       32'(data_out), 32'hE6);
        checkOutput("e6_no_ferr",    32'(ferrCount - f0), 32'd0);
        checkOutput("e6_busy_len",   32'(lastBusyLen), 32'(BUSY_CLKS));

        // Framing error on 8'h4B
        d0 = doneCount; f0 = ferrCount;
        applyStimulus(8'h4B, 1'b0);
        #(2 * BIT_NS);
        checkOutput("ferr_count",   32'(ferrCount - f0), 32'd1);
        checkOutput("ferr_no_done", 32'(doneCount - d0), 32'd0);
        checkOutput("ferr_data",    32'(data_out), 32'hE6);

        // Back-to-back 8'h00 then 8'hFF
        d0 = doneCount; idx = doneData.size();
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        #(BIT_NS);
        checkOutput("b2b_done_count", 32'(doneCount - d0), 32'd2);
        checkOutput("b2b_first",
                    (doneData.size() > idx) ? 32'(doneData[idx]) : 32'hBAD, 32'h00);
        checkOutput("b2b_second",
                    (doneData.size() > idx + 1) ? 32'(doneData[idx + 1]) : 32'hBAD, 32'hFF);
        checkOutput("b2b_data", 32'(data_out), 32'hFF);

        // Enable gating: 8'hA5 ignored, then 8'h5A accepted
        rx_en = 1'b0;
        d0 = doneCount; b0 = busyRise;
        applyStimulus(8'hA5, 1'b1);
        #(BIT_NS);
        checkOutput("gate_no_busy", 32'(busyRise - b0), 32'd0);
        checkOutput("gate_no_done", 32'(doneCount - d0), 32'd0);
        checkOutput("gate_data",    32'(data_out), 32'hFF);
        rx_en = 1'b1;
        #(BIT_NS);
        applyStimulus(8'h5A, 1'b1);
        #(BIT_NS);
        checkOutput("en_data_5a", 32'(data_out), 32'h5A);

        // Reset during bit 4 of a 8'h3C frame
        partial = 8'h3C;
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx = partial[i];
            #(BIT_NS);
        end
        rx = partial[4];
        #(BIT_NS / 2);
        checkOutput("mid_busy_before", 32'(busy), 32'h1);
        arst_n = 1'b0;
        #1;
        checkOutput("mid_rst_data",  32'(data_out),  32'h00);
        checkOutput("mid_rst_busy",  32'(busy),      32'h0);
        checkOutput("mid_rst_done",  32'(done),      32'h0);
        checkOutput("mid_rst_ferr",  32'(frame_err), 32'h0);
        rx = 1'b1;
        #(10 * CLK_NS);
        @(negedge clk);
        arst_n = 1'b1;
        #(2 * BIT_NS);
        d0 = doneCount;
        applyStimulus(8'h3C, 1'b1);
        #(BIT_NS);
        checkOutput("post_rst_done", 32'(doneCount - d0), 32'd1);
        checkOutput("post_rst_data", 32'(data_out), 32'h3C);

        // End-to-end frame of the byte a transmitter would send for 8'hE6
        applyStimulus(8'hE6, 1'b1);
        #(BIT_NS);
        checkOutput("e2e_data", 32'(data_out), 32'hE6);

        checkOutput("done_ferr_exclusive", 32'(bothHigh), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_rx

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Asynchronous serial receiver: 8 data bits, no parity, 1 stop bit, LSB first, idle line high. It is the receive-side counterpart of the existing uart_tx and uses the same UART_INPUT_CLK / baud_rate parameterisation and the same 16x oversampling tick (divisor 651 at 100 MHz / 9600). It recovers bytes from the external rx pin and presents each one with a single-cycle done strobe to the host logic.

Parameters:
UART_INPUT_CLK, 100_000_000, input clock frequency in Hz
baud_rate, 9600, line rate in bit/s; oversampling divisor DIV = UART_INPUT_CLK / (baud_rate*16), integer-truncated

Ports:
clk  input  1  system clock
arst_n  input  1  asynchronous active-low reset
rx_en  input  1  receive enable; a new frame is accepted only while high
rx  input  1  serial line, asynchronous to clk
data_out  output  8  last correctly received byte
done  output  1  one-cycle pulse when data_out is updated
busy  output  1  high from start-bit acceptance until the frame ends
frame_err  output  1  one-cycle pulse when the stop bit samples low

Behaviour:
- Reset (arst_n low, asynchronous): data_out=8'h00, done=0, busy=0, frame_err=0, FSM=IDLE, tick counter=0, synchroniser flops=1 (line idle).
- rx passes through a 2-FF synchroniser; all logic uses the synchronised value rx_s.
- Tick generator: free-running counter 0..DIV-1. btick pulses for one clk when the counter equals DIV-1, then the counter wraps to 0. Period is 651 clk at the defaults. One bit = 16 bticks = 104160 ns at the defaults.
- FSM states: IDLE, START, DATA, STOP. Per-state sample counter s_cnt is 4 bits; bit index b_cnt is 3 bits.
- IDLE: busy=0. If rx_en=1 and rx_s=0 on a btick, go to START, set s_cnt=0 and busy=1. While rx_en=0, a low line is ignored.
- START: count bticks. When s_cnt reaches 7 (mid start bit), re-check rx_s.
  - rx_s=0: go to DATA, s_cnt=0, b_cnt=0.
  - rx_s=1: glitch; return to IDLE with busy=0. No done, no frame_err.
- DATA: on each btick where s_cnt=15, shift rx_s into the MSB of the shift register (LSB-first reception) and reset s_cnt to 0. After b_cnt=7 is sampled, go to STOP.
- STOP: on the btick where s_cnt=15 (mid stop bit):
  - rx_s=1: data_out <= shift register, done=1 for exactly one clk.
  - rx_s=0: frame_err=1 for exactly one clk; data_out holds its previous value.
  - In both cases go to IDLE with busy=0 in the same cycle.
  - done and frame_err are never high together.
- Latency: done rises about 9.5 bit times plus 2–3 clk after the rx falling edge. Start-edge phase uncertainty is up to 1 btick, so sampling lands at mid-bit ±1/16 bit.
- Back-to-back frames: the start bit immediately following a stop bit must be accepted. IDLE is entered at mid stop bit, so the next falling edge is detectable.
- rx_en deasserted mid-frame: the current frame completes normally; gating applies only at IDLE.
- arst_n asserted mid-frame: immediate return to reset values. A partially received byte is discarded. After release the receiver waits for a new falling edge; if the line is low at release, that level is treated as a start candidate and filtered by the START check.

Decomposition:
- Package uart_pkg: FSM state encoding (IDLE, START, DATA, STOP), OVERSAMPLE=16, DATA_BITS=8, STOP_SAMPLE=15, MID_START=7. It is shared with uart_tx.
- Sub-module uart_baud_gen (parameters UART_INPUT_CLK, baud_rate; ports clk, arst_n, btick). It is reusable by uart_tx.
- The FSM, datapath and synchroniser stay in uart_rx.

Test Plan:
- Single frame: after reset, rx_en=1, drive 8'hE6 LSB-first at 104160 ns/bit with stop=1 -> exactly one done pulse, data_out=8'hE6, busy high for ~9.5 bits, frame_err never high.
- Glitch rejection: rx low for 3 btick periods (~19530 ns) then high -> busy rises then falls within 8 bticks, no done, no frame_err, data_out unchanged (8'h00).
- Framing error: after 8'hE6 is received, send 8'h4B with stop bit 0 -> one frame_err pulse, no done, data_out stays 8'hE6.
- Back-to-back: 8'h00 then 8'hFF with no idle gap -> two done pulses, data_out=8'h00 then 8'hFF.
- Enable gating: rx_en=0 during a full 8'hA5 frame -> no busy, no done. Then rx_en=1 and send 8'h5A -> data_out=8'h5A.
- Reset mid-frame / loopback: pulse arst_n low during bit 4 -> all outputs 0 immediately, and the following 8'h3C frame is received correctly. Connect uart_tx.tx to rx with data_in=8'hE6 -> data_out=8'hE6.
